matrixmult_result_drain: RTL and testbench

Reader for the matrix-multiply output buffer. Starts when the multiply engine raises `done`, reads the Q10.10 result buffer through its address/enable read port, and applies an optional ReLU. Streams each result in address order as a valid/ready stream, suitable for driving the next layer's multiplier load port (`enableReadMultiplier` / `multiplier`). Hides the buffer's fixed read latency with a credit-limited FIFO and sustains one word per cycle.

---
 rtl/matrixmult_result_drain.sv | 182 ++++++++++++++++++
 tb/tb_matrixmult_result_drain.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrixmult_result_drain.sv
// Result drain for the matrix-multiply output buffer.
// After the multiply engine raises mm_done, reads the Q10.10 result buffer in
// address order and streams each word as valid/ready, with optional ReLU.
// A small credit-limited FIFO hides the buffer read latency so one word per
// cycle is sustained when the consumer is always ready.
module matrixmult_result_drain #(
  parameter int OUTPUT_SIZE  = 3,
  parameter int DATA_WIDTH   = 20,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2,
  parameter int RELU_EN      = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mm_done,
  output logic [ADDR_WIDTH-1:0]        mm_addr,
  output logic                         mm_enable,
  input  logic signed [DATA_WIDTH-1:0] mm_data,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_data,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         finished,
  output logic                         aborted
);

  // Room for every read that can be in the latency pipe plus two words of
  // slack, which is what keeps issue running back-to-back.
  localparam int FIFO_DEPTH = READ_LATENCY + 2;
  localparam int CNT_W      = $clog2(OUTPUT_SIZE + 1);
  localparam int FC_W       = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    done_q;
  logic [CNT_W-1:0]        issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]        xfer_cnt_q, xfer_cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [READ_LATENCY-1:0] rd_vld_q, rd_vld_d;
  logic [FC_W-1:0]         in_flight_q, in_flight_d;
  logic [FC_W-1:0]         fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic                    finished_q, finished_d;
  logic                    aborted_q, aborted_d;
  logic signed [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];

  logic            done_rise;
  logic            in_drain;
  logic            live;
  logic            credit;
  logic            issue;
  logic            ret;
  logic            push;
  logic            pop;
  logic [FC_W:0]   outstanding;

  // Negative words clamp to zero when ReLU is enabled.
  function automatic logic signed [DATA_WIDTH-1:0] relu(input logic signed [DATA_WIDTH-1:0] w);
    if ((RELU_EN != 0) && w[DATA_WIDTH-1]) return '0;
    return w;
  endfunction

  // FIFO pointer advance with wrap for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign done_rise   = mm_done & ~done_q;
  assign in_drain    = (state_q == DRAIN);
  // Dropping mm_done ends ownership of the read port immediately.
  assign live        = in_drain & mm_done;
  assign outstanding = {1'b0, in_flight_q} + {1'b0, fifo_cnt_q};
  assign credit      = outstanding < (FC_W + 1)'(FIFO_DEPTH);
  assign issue       = live && (issue_cnt_q < CNT_W'(OUTPUT_SIZE)) && credit;
  assign ret         = rd_vld_q[READ_LATENCY-1];
  // Returns after an abort are discarded rather than stored.
  assign push        = ret & in_drain;
  assign pop         = out_valid & out_ready;

  assign mm_enable   = issue;
  assign mm_addr     = issue ? ADDR_WIDTH'(issue_cnt_q) : addr_q;
  assign out_valid   = live && (fifo_cnt_q != '0);
  assign out_data    = out_valid ? fifo_mem_q[rd_ptr_q] : '0;
  assign busy        = (state_q != IDLE);
  assign finished    = finished_q;
  assign aborted     = aborted_q;

  // Next-state logic for the drain sequencer, counters and FIFO bookkeeping.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q + CNT_W'(issue);
    xfer_cnt_d  = xfer_cnt_q + CNT_W'(pop);
    addr_d      = issue ? ADDR_WIDTH'(issue_cnt_q) : addr_q;
    rd_vld_d    = READ_LATENCY'({rd_vld_q, issue});
    in_flight_d = in_flight_q + FC_W'(issue) - FC_W'(ret);
    fifo_cnt_d  = fifo_cnt_q + FC_W'(push) - FC_W'(pop);
    wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    finished_d  = 1'b0;
    aborted_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (done_rise) begin
          state_d     = DRAIN;
          issue_cnt_d = '0;
          xfer_cnt_d  = '0;
          in_flight_d = '0;
          rd_vld_d    = '0;
          fifo_cnt_d  = '0;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
        end
      end
      DRAIN: begin
        if (!mm_done) begin
          state_d   = FLUSH;
          aborted_d = 1'b1;
        end else if (pop && (xfer_cnt_q == CNT_W'(OUTPUT_SIZE - 1))) begin
          state_d    = IDLE;
          finished_d = 1'b1;
        end
      end
      FLUSH: begin
        if (in_flight_q == '0) begin
          state_d    = IDLE;
          fifo_cnt_d = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state register; reset also discards any reads still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      issue_cnt_q <= '0;
      xfer_cnt_q  <= '0;
      addr_q      <= '0;
      rd_vld_q    <= '0;
      in_flight_q <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      finished_q  <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= mm_done;
      issue_cnt_q <= issue_cnt_d;
      xfer_cnt_q  <= xfer_cnt_d;
      addr_q      <= addr_d;
      rd_vld_q    <= rd_vld_d;
      in_flight_q <= in_flight_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      finished_q  <= finished_d;
      aborted_q   <= aborted_d;
    end
  end

  // FIFO storage: ReLU is applied on the way in so the head is final.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= relu(mm_data);
  end

endmodule

// File: tb/tb_matrixmult_result_drain.sv
// Bench for matrixmult_result_drain: two instances (3 words with ReLU,
// 10 words without), a latency-2 buffer model each, a scoreboard queue per
// instance filled by the stimulus and drained by a monitor.
module tb_matrixmult_result_drain;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        a_done, a_en, a_valid, a_ready, a_busy, a_fin, a_abt;
  logic [9:0]  a_addr;
  logic [19:0] a_data, a_out;
  logic        b_done, b_en, b_valid, b_ready, b_busy, b_fin, b_abt;
  logic [9:0]  b_addr;
  logic [19:0] b_data, b_out;

  matrixmult_result_drain #(.OUTPUT_SIZE(3), .DATA_WIDTH(20), .ADDR_WIDTH(10),
                            .READ_LATENCY(2), .RELU_EN(1)) u_dut_a (
    .clk(clk), .reset(reset), .mm_done(a_done), .mm_addr(a_addr), .mm_enable(a_en),
    .mm_data(a_data), .out_valid(a_valid), .out_data(a_out), .out_ready(a_ready),
    .busy(a_busy), .finished(a_fin), .aborted(a_abt));

  matrixmult_result_drain #(.OUTPUT_SIZE(10), .DATA_WIDTH(20), .ADDR_WIDTH(10),
                            .READ_LATENCY(2), .RELU_EN(0)) u_dut_b (
    .clk(clk), .reset(reset), .mm_done(b_done), .mm_addr(b_addr), .mm_enable(b_en),
    .mm_data(b_data), .out_valid(b_valid), .out_data(b_out), .out_ready(b_ready),
    .busy(b_busy), .finished(b_fin), .aborted(b_abt));

  // Result buffers with a fixed two-cycle read latency.
  logic [19:0] bufA [3];
  logic [19:0] bufB [10];
  logic [19:0] pipeA [2];
  logic [19:0] pipeB [2];
  always @(posedge clk) begin
    pipeA[0] <= (a_en && a_addr < 10'd3) ? bufA[a_addr] : 20'h5A5A5;
    pipeA[1] <= pipeA[0];
    pipeB[0] <= (b_en && b_addr < 10'd10) ? bufB[b_addr] : 20'h5A5A5;
    pipeB[1] <= pipeB[0];
  end
  assign a_data = pipeA[1];
  assign b_data = pipeB[1];

  int errors = 0;
  int checks = 0;
  logic [19:0] expA [$];
  logic [19:0] expB [$];
  int expAddrA, issuedA, xferA, finA = 0, abtA = 0;
  int expAddrB, issuedB, xferB, finB = 0, abtB = 0;
  logic a_hold = 1'b0, b_hold = 1'b0;
  logic [19:0] a_hold_data, b_hold_data, eA, eB;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] relu_ref(input logic [19:0] w, input bit en);
    if (en && w[19]) return 20'h0;
    return w;
  endfunction

  // Monitor for instance A: address order, credit limit, hold stability, data.
  always @(negedge clk) begin
    if (reset) a_hold = 1'b0;
    else begin
      if (a_en) begin
        issuedA++;
        check("A_addr_order", 32'(a_addr), 32'(expAddrA));
        check("A_credit", 32'((issuedA - xferA) <= 4), 32'd1);
        expAddrA++;
      end
      if (a_hold && a_done) begin
        check("A_hold_valid", 32'(a_valid), 32'd1);
        check("A_hold_data", 32'(a_out), 32'(a_hold_data));
      end
      if (a_valid && a_ready) begin
        xferA++;
        if (expA.size() == 0) begin
          checks++; errors++;
          $display("FAIL A_unexpected_word actual=%0h required=none", a_out);
        end else begin
          eA = expA.pop_front();
          check("A_data", 32'(a_out), 32'(eA));
        end
      end
      a_hold = a_valid && !a_ready;
      a_hold_data = a_out;
      if (a_fin) finA++;
      if (a_abt) abtA++;
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (reset) b_hold = 1'b0;
    else begin
      if (b_en) begin
        issuedB++;
        check("B_addr_order", 32'(b_addr), 32'(expAddrB));
        check("B_credit", 32'((issuedB - xferB) <= 4), 32'd1);
        expAddrB++;
      end
      if (b_hold && b_done) begin
        check("B_hold_valid", 32'(b_valid), 32'd1);
        check("B_hold_data", 32'(b_out), 32'(b_hold_data));
      end
      if (b_valid && b_ready) begin
        xferB++;
        if (expB.size() == 0) begin
          checks++; errors++;
          $display("FAIL B_unexpected_word actual=%0h required=none", b_out);
        end else begin
          eB = expB.pop_front();
          check("B_data", 32'(b_out), 32'(eB));
        end
      end
      b_hold = b_valid && !b_ready;
      b_hold_data = b_out;
      if (b_fin) finB++;
      if (b_abt) abtB++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_a(input bit with_exp);
    expAddrA = 0; issuedA = 0; xferA = 0;
    if (with_exp) for (int i = 0; i < 3; i++) expA.push_back(relu_ref(bufA[i], 1'b1));
    tick();
    a_done = 1'b1;
  endtask

  task automatic start_b(input bit with_exp);
    expAddrB = 0; issuedB = 0; xferB = 0;
    if (with_exp) for (int i = 0; i < 10; i++) expB.push_back(relu_ref(bufB[i], 1'b0));
    tick();
    b_done = 1'b1;
  endtask

  task automatic wait_fin_a(input bit rnd);
    int f0 = finA;
    bit got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (rnd) a_ready = 1'($urandom_range(0, 1));
      tick();
      if (finA != f0) begin got = 1'b1; break; end
    end
    a_ready = 1'b1;
    check("A_finished_seen", 32'(got), 32'd1);
    check("A_queue_empty", 32'(expA.size()), 32'd0);
  endtask

  task automatic wait_fin_b(input bit rnd);
    int f0 = finB;
    bit got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (rnd) b_ready = 1'($urandom_range(0, 1));
      tick();
      if (finB != f0) begin got = 1'b1; break; end
    end
    b_ready = 1'b1;
    check("B_finished_seen", 32'(got), 32'd1);
    check("B_queue_empty", 32'(expB.size()), 32'd0);
  endtask

  initial begin
    logic [19:0] dirA [3];
    int cnt, f0, a0;
    reset = 1'b1;
    a_done = 1'b0; a_ready = 1'b1;
    b_done = 1'b0; b_ready = 1'b1;
    repeat (3) tick();
    check("rst_addr", 32'(a_addr), 32'd0);
    check("rst_en", 32'(a_en), 32'd0);
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_data", 32'(a_out), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_fin", 32'(a_fin), 32'd0);
    check("rst_abt", 32'(a_abt), 32'd0);
    reset = 1'b0;
    repeat (2) tick();

    // Directed 3-word drain with ReLU, consumer always ready.
    bufA[0] = 20'h00400; bufA[1] = 20'hFFC00; bufA[2] = 20'h00C00;
    dirA[0] = 20'h00400; dirA[1] = 20'h00000; dirA[2] = 20'h00C00;
    start_a(1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("A_dir_busy", 32'(a_busy), 32'(c >= 1 && c <= 6));
      check("A_dir_en", 32'(a_en), 32'(c >= 1 && c <= 3));
      if (c >= 1 && c <= 3) check("A_dir_addr", 32'(a_addr), 32'(c - 1));
      check("A_dir_valid", 32'(a_valid), 32'(c >= 4 && c <= 6));
      if (c >= 4 && c <= 6) check("A_dir_data", 32'(a_out), 32'(dirA[c-4]));
      check("A_dir_fin", 32'(a_fin), 32'(c == 7));
    end
    // mm_done stays high: edge-triggered, so no second drain.
    cnt = 0; f0 = finA;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (a_en || a_valid || a_busy) cnt++;
    end
    check("A_no_redrain", 32'(cnt), 32'd0);
    check("A_fin_count", 32'(finA - f0), 32'd0);
    a_done = 1'b0;
    repeat (2) tick();

    // Randomized drains on A with random back-pressure.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 3; i++) bufA[i] = 20'($urandom);
      if (k == 0) begin bufA[0] = 20'h80000; bufA[1] = 20'h7FFFF; end
      start_a(1'b1);
      wait_fin_a(1'b1);
      a_done = 1'b0;
      repeat (2) tick();
    end

    // Same buffer data without ReLU: 0xFFC00 passes through. Ready low for
    // cycles 0-12 limits outstanding reads to four.
    for (int i = 0; i < 10; i++) bufB[i] = 20'($urandom);
    bufB[0] = 20'h00400; bufB[1] = 20'hFFC00; bufB[2] = 20'h00C00;
    b_ready = 1'b0;
    f0 = finB;
    start_b(1'b1);
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (c == 12) check("B_issued_before_ready", 32'(issuedB), 32'd4);
      if (c == 12) check("B_valid_held", 32'(b_valid), 32'd1);
    end
    tick();
    b_ready = 1'b1;
    wait_fin_b(1'b0);
    check("B_single_fin", 32'(finB - f0), 32'd1);
    b_done = 1'b0;
    repeat (2) tick();

    // Abort: mm_done drops in cycle 3.
    f0 = finB; a0 = abtB;
    start_b(1'b0);
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      check("B_abt_pulse", 32'(b_abt), 32'(c == 4));
      check("B_abt_valid", 32'(b_valid), 32'd0);
      if (c >= 8) check("B_abt_idle", 32'(b_busy), 32'd0);
      if (c == 2) begin tick(); b_done = 1'b0; end
    end
    check("B_abt_no_fin", 32'(finB - f0), 32'd0);
    check("B_abt_count", 32'(abtB - a0), 32'd1);
    for (int i = 0; i < 10; i++) bufB[i] = 20'($urandom);
    start_b(1'b1);
    wait_fin_b(1'b0);
    b_done = 1'b0;
    repeat (2) tick();

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 10; i++) bufB[i] = 20'($urandom);
    f0 = finB;
    start_b(1'b1);
    repeat (6) tick();
    @(posedge clk); #3;
    reset = 1'b1;
    b_done = 1'b0;
    #1;
    check("B_rst_addr", 32'(b_addr), 32'd0);
    check("B_rst_en", 32'(b_en), 32'd0);
    check("B_rst_valid", 32'(b_valid), 32'd0);
    check("B_rst_data", 32'(b_out), 32'd0);
    check("B_rst_busy", 32'(b_busy), 32'd0);
    check("B_rst_fin", 32'(b_fin), 32'd0);
    check("B_rst_abt", 32'(b_abt), 32'd0);
    expB.delete();
    tick();
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (b_en || b_valid || b_busy) cnt++;
    end
    check("B_quiet_after_reset", 32'(cnt), 32'd0);
    check("B_rst_no_fin", 32'(finB - f0), 32'd0);

    // Randomized drains on B.
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 10; i++) bufB[i] = 20'($urandom);
      start_b(1'b1);
      wait_fin_b(1'b1);
      b_done = 1'b0;
      repeat ($urandom_range(1, 4)) tick();
    end

    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
